// File: rtl/instr_decode_queue.sv
// Instruction prefetch queue between memory and decode: a DEPTH-entry FIFO whose
// head word is presented, already split into opcode and address fields.
module instr_decode_queue #(
  parameter int INS_W = 8,
  parameter int OP_W  = 3,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [INS_W-1:0]           mem_ins,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OP_W-1:0]            Opcode,
  output logic [INS_W-OP_W-1:0]      Address,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int ADDR_W = INS_W - OP_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [INS_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [INS_W-1:0] head_r, head_nxt_s;
  logic             valid_r, ready_r;
  logic             push_s, pop_s;

  // Handshakes only look at registered state, so in_ready never depends on out_ready.
  assign push_s = in_valid && ready_r && !flush;
  assign pop_s  = valid_r && out_ready && !flush;

  // Next-state pointers, occupancy and the head word the queue will present after the edge.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = {INS_W{1'b0}};
    if (flush) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
    // The new head may be the word being written on this very edge.
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {INS_W{1'b0}};
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = mem_ins;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Queue storage; validity is defined by pointers and count alone, so no reset here.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= mem_ins;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {INS_W{1'b0}};
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
      ready_r  <= (count_nxt_s < CNT_W'(DEPTH));
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign count     = count_r;
  assign Opcode    = head_r[INS_W-1:ADDR_W];
  assign Address   = head_r[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench: default 8-bit/4-deep queue plus a 12-bit/8-deep instance.
module tb_instr_decode_queue;

  logic        Clk = 1'b0;
  logic        Reset;

  logic [7:0]  a_ins;
  logic        a_iv, a_fl, a_or, a_ir, a_ov;
  logic [2:0]  a_op;
  logic [4:0]  a_ad;
  logic [2:0]  a_cnt;

  logic [11:0] b_ins;
  logic        b_iv, b_fl, b_or, b_ir, b_ov;
  logic [3:0]  b_op;
  logic [7:0]  b_ad;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  instr_decode_queue dut_a (
    .Clk(Clk), .Reset(Reset), .mem_ins(a_ins), .in_valid(a_iv), .in_ready(a_ir),
    .flush(a_fl), .out_ready(a_or), .out_valid(a_ov), .Opcode(a_op), .Address(a_ad),
    .count(a_cnt)
  );

  instr_decode_queue #(.INS_W(12), .OP_W(4), .DEPTH(8)) dut_b (
    .Clk(Clk), .Reset(Reset), .mem_ins(b_ins), .in_valid(b_iv), .in_ready(b_ir),
    .flush(b_fl), .out_ready(b_or), .out_valid(b_ov), .Opcode(b_op), .Address(b_ad),
    .count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    a_ins = 8'h00;  a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b0;
    b_ins = 12'h000; b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b0;
    #3;
    check("rst_cnt", a_cnt, 3'd0);
    check("rst_ov", a_ov, 1'b0);
    check("rst_ir", a_ir, 1'b1);
    check("rst_head", {a_op, a_ad}, 8'h00);
    check("rst_b_cnt", b_cnt, 4'd0);
    cyc();
    cyc();
    Reset = 1'b0;

    // single word
    a_ins = 8'hA7; a_iv = 1'b1;
    cyc();
    a_iv = 1'b0;
    check("single_ov", a_ov, 1'b1);
    check("single_op", a_op, 3'b101);
    check("single_ad", a_ad, 5'b00111);
    check("single_cnt", a_cnt, 3'd1);
    a_or = 1'b1;
    cyc();
    check("pop_ov", a_ov, 1'b0);
    check("pop_head", {a_op, a_ad}, 8'h00);
    check("pop_cnt", a_cnt, 3'd0);
    cyc();
    check("empty_pop_cnt", a_cnt, 3'd0);
    check("empty_pop_ov", a_ov, 1'b0);
    a_or = 1'b0;

    // fill to full
    a_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_ins = 8'((i + 1) * 8'h21);
      cyc();
    end
    check("full_cnt", a_cnt, 3'd4);
    check("full_ir", a_ir, 1'b0);
    a_ins = 8'hFF;
    cyc();
    check("full_ignore_cnt", a_cnt, 3'd4);
    check("full_ignore_head", {a_op, a_ad}, 8'h21);
    a_or = 1'b1;
    cyc();
    check("full_pop_cnt", a_cnt, 3'd3);
    check("full_pop_ir", a_ir, 1'b1);
    a_iv = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("drain_op", a_op, 32'(i + 1));
      check("drain_ad", a_ad, 32'(i + 1));
      cyc();
    end
    a_or = 1'b0;
    check("drain_cnt", a_cnt, 3'd0);

    // concurrent push/pop across pointer wrap
    a_iv = 1'b1;
    a_ins = 8'h10; cyc();
    a_ins = 8'h11; cyc();
    check("wrap_pre_cnt", a_cnt, 3'd2);
    a_or = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("wrap_head", {a_op, a_ad}, 32'(8'h10 + k));
      a_ins = 8'(8'h12 + k);
      cyc();
      check("wrap_cnt", a_cnt, 3'd2);
    end
    a_or = 1'b0;
    check("wrap_end_head", {a_op, a_ad}, 8'h1A);

    // flush with push and pop requested
    a_ins = 8'h1C; cyc();
    check("flush_pre_cnt", a_cnt, 3'd3);
    a_fl = 1'b1; a_ins = 8'h55; a_or = 1'b1;
    cyc();
    a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
    check("flush_cnt", a_cnt, 3'd0);
    check("flush_ov", a_ov, 1'b0);
    check("flush_ir", a_ir, 1'b1);
    check("flush_head", {a_op, a_ad}, 8'h00);
    cyc();
    check("flush_no_word", a_cnt, 3'd0);
    a_iv = 1'b1; a_ins = 8'h77; cyc();
    check("post_flush_head", {a_op, a_ad}, 8'h77);
    a_ins = 8'h01; cyc();
    a_ins = 8'h02; cyc();
    a_iv = 1'b0;
    check("areset_pre_cnt", a_cnt, 3'd3);

    // asynchronous reset between edges
    #2;
    Reset = 1'b1;
    #1;
    check("areset_cnt", a_cnt, 3'd0);
    check("areset_ov", a_ov, 1'b0);
    check("areset_ir", a_ir, 1'b1);
    check("areset_head", {a_op, a_ad}, 8'h00);
    #2;
    Reset = 1'b0;
    a_iv = 1'b1; a_ins = 8'h1F;
    cyc();
    a_iv = 1'b0;
    check("rel_op", a_op, 3'd0);
    check("rel_ad", a_ad, 5'h1F);
    check("rel_cnt", a_cnt, 3'd1);

    // wide/deep instance: single word
    b_iv = 1'b1; b_ins = 12'hA57;
    cyc();
    b_iv = 1'b0;
    check("b_single_op", b_op, 4'hA);
    check("b_single_ad", b_ad, 8'h57);
    check("b_single_cnt", b_cnt, 4'd1);
    b_or = 1'b1;
    cyc();
    b_or = 1'b0;
    check("b_pop_ov", b_ov, 1'b0);
    check("b_pop_head", {b_op, b_ad}, 12'h000);

    // wide/deep instance: fill to 8, ignored ninth, ordered drain
    b_iv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_ins = 12'((i + 1) * 12'h101);
      cyc();
    end
    check("b_full_cnt", b_cnt, 4'd8);
    check("b_full_ir", b_ir, 1'b0);
    b_ins = 12'hFFF;
    cyc();
    b_iv = 1'b0;
    check("b_full_ignore_cnt", b_cnt, 4'd8);
    b_or = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b_drain_op", b_op, 32'(i + 1));
      check("b_drain_ad", b_ad, 32'(i + 1));
      cyc();
    end
    b_or = 1'b0;
    check("b_drain_cnt", b_cnt, 4'd0);

    // wide/deep instance: concurrent push/pop across wrap
    b_iv = 1'b1;
    b_ins = 12'h300; cyc();
    b_ins = 12'h301; cyc();
    b_or = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("b_wrap_head", {b_op, b_ad}, 32'(12'h300 + k));
      b_ins = 12'(12'h302 + k);
      cyc();
      check("b_wrap_cnt", b_cnt, 4'd2);
    end
    b_iv = 1'b0; b_or = 1'b0;
    check("b_wrap_end_head", {b_op, b_ad}, 12'h30A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 The block SHALL take parameter INS_W, default 8, meaning instruction word width in bits.
REQ-002 The block SHALL take parameter OP_W, default 3, meaning opcode field width; ADDR_W = INS_W - OP_W (default 5).
REQ-003 The block SHALL take parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-004 Clk  input  1  clock; all state changes on rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 mem_ins  input  INS_W  instruction word from memory; opcode in [INS_W-1:ADDR_W], address in [ADDR_W-1:0].
REQ-007 in_valid  input  1  mem_ins valid this cycle.
REQ-008 in_ready  output  1  queue can accept a word this cycle.
REQ-009 flush  input  1  synchronous discard of all queued words (branch/jump).
REQ-010 out_ready  input  1  decode stage accepts head this cycle.
REQ-011 out_valid  output  1  Opcode/Address hold a valid queued instruction.
REQ-012 Opcode  output  OP_W  opcode field of head entry.
REQ-013 Address  output  ADDR_W  address field of head entry.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 Push SHALL occur on an edge where in_valid && in_ready && !flush; word written at write pointer, write pointer +1 modulo DEPTH.
REQ-016 Pop SHALL occur on an edge where out_valid && out_ready && !flush; read pointer +1 modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH), registered-state only, no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 Opcode/Address SHALL be the split fields of the entry at the read pointer when out_valid=1, and all zeros when out_valid=0.
REQ-020 Latency: a word pushed into an empty queue SHALL appear on Opcode/Address with out_valid=1 in the cycle after the push edge.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Full (count=DEPTH): in_ready=0, in_valid ignored, contents held; a pop in that cycle frees one entry from the next cycle.
REQ-023 Empty (count=0): out_ready ignored, pointers and count held.
REQ-024 flush=1 SHALL on the next edge set count=0 and both pointers to 0; any push or pop requested in the same cycle is discarded.
REQ-025 Ordering SHALL be strict FIFO; no word lost or duplicated across pointer wrap.
REQ-026 Storage contents need not be cleared by reset or flush; only pointers and count define validity.

Reset
REQ-027 While Reset=1: count=0, pointers=0, out_valid=0, Opcode=0, Address=0, in_ready=1, independent of Clk.
REQ-028 Reset asserted mid-operation SHALL discard all queued words immediately; first push after release behaves as into an empty queue.

Verification
REQ-029 Single word: push 8'hA7 into empty queue -> next cycle out_valid=1, Opcode=3'b101, Address=5'b00111, count=1; pop -> out_valid=0, Opcode=0, Address=0.
REQ-030 Fill/full: push 8'h21,8'h42,8'h63,8'h84 with out_ready=0 -> count=4, in_ready=0; fifth push 8'hFF ignored; pops return opcodes 1,2,3,4 in order.
REQ-031 Wrap and concurrency: with count=2, hold in_valid and out_ready high 10 cycles with incrementing words -> count stays 2, outputs strictly in push order across pointer wrap.
REQ-032 Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, flushed-cycle word absent.
REQ-033 Async reset: count=3, raise Reset between clock edges -> outputs zero and in_ready=1 before next edge; after release, push 8'h1F -> Opcode=0, Address=5'h1F.
REQ-034 Parameter sweep: repeat REQ-029 to REQ-031 with INS_W=12, OP_W=4, DEPTH=8 -> field split and full at count=8 correct.
